raygroup_scheduler: RTL and testbench
=====================================

# raygroup_scheduler

Shares the two ray-group engine channels of the boundtop core (channel 01 and channel 10) between NUM_REQ upstream requesters. Requesters submit 2-bit ray-group IDs over a valid/ready handshake. A round-robin arbiter grants one requester per cycle onto a free channel. Per-channel FSMs sequence the raygroupvalid/busy exchange and report completion back to the owning requester.

## Interface
- NUM_REQ, 4: number of upstream requesters (2..8).
- REQ_W, $clog2(NUM_REQ): width of a requester index.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles; used only with RGSCHED_TIMEOUT_EN.
- clk  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester submit request.
- req_group  in  2*NUM_REQ  ray-group ID; requester i drives bits [2i+1:2i].
- req_ready  out  NUM_REQ  one-hot grant; transfer happens when req_valid[i] and req_ready[i] are both high at a clk edge.
- raygroup01  out  2  ray-group ID issued to channel 01.
- raygroupvalid01  out  1  one-cycle issue strobe for channel 01.
- busy01  in  1  channel 01 engine busy.
- raygroup10, raygroupvalid10, busy10: same as above, for channel 10.
- done_valid  out  1  one-cycle completion pulse.
- done_req  out  REQ_W  index of the completed requester.
- done_chan  out  1  completed channel (0 = channel 01, 1 = channel 10).
- timeout_err  out  1  sticky watchdog flag; tied to 0 without RGSCHED_TIMEOUT_EN.

## Operation
- Arbiter:
  - Grants only when at least one channel FSM is IDLE.
  - Picks the first requester with req_valid high, searching round-robin from rr_ptr.
  - Target channel is channel 01 if it is IDLE, otherwise channel 10.
  - req_ready is combinational from req_valid, rr_ptr and channel state. It is at most one-hot and all zero when no channel is IDLE.
  - On a transfer, rr_ptr moves to (granted index + 1) mod NUM_REQ and wraps. With no transfer, rr_ptr holds.
- Channel FSM (one per channel). States: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
  - IDLE -> ISSUE on a transfer to this channel. The ray-group ID and owner index are latched.
  - ISSUE: raygroupvalidXX = 1 for this cycle only. Next state is WAIT_BUSY.
  - WAIT_BUSY -> RUN when busyXX = 1.
  - RUN -> DONE when busyXX = 0.
  - DONE -> IDLE in the cycle its completion is reported on done_*.
- raygroupXX holds the latched ID from ISSUE until the channel returns to IDLE. It is 0 in IDLE.
- Completion report:
  - done_valid, done_req and done_chan are registered and appear in the cycle after DONE is selected for reporting.
  - If both channels are in DONE in the same cycle, channel 01 is reported first and channel 10 waits in DONE for one more cycle.
- A grant and a completion may happen in the same cycle. A channel leaving DONE is not grantable until the following cycle.
- Reset, including mid-operation: all FSMs go to IDLE, rr_ptr = 0, and latched IDs and owners are cleared. In-flight groups are dropped and not reported.
- Reset values: req_ready 0, raygroup01/10 0, raygroupvalid01/10 0, done_valid 0, done_req 0, done_chan 0, timeout_err 0.

## Timing
- Transfer at edge N -> raygroupvalidXX high in cycle N+1 -> WAIT_BUSY from N+2.
- busyXX falling edge seen in cycle M -> DONE in M+1 -> done_valid in M+2, when the report is not delayed by the other channel.
- Shortest turnaround: when busy is high for one cycle, the channel is grantable again 4 cycles after ISSUE.
- No combinational path from busy01/10 to any output.

## Configuration
- RGSCHED_TIMEOUT_EN defined:
  - Each channel has a cycle counter that clears on entering ISSUE and counts during WAIT_BUSY and RUN.
  - When the count reaches TIMEOUT_CYCLES, the channel is forced to DONE, reports normally and sets timeout_err. timeout_err clears only on reset.
- RGSCHED_TIMEOUT_EN undefined: no counters exist, timeout_err is constant 0 and the channels wait indefinitely.

## Structure
- Package raygroup_sched_pkg:
  - chan_state_e enum (IDLE, ISSUE, WAIT_BUSY, RUN, DONE).
  - CHAN01 = 1'b0, CHAN10 = 1'b1.
  - raygroup_t (logic [1:0]).
- Sub-module rr_arbiter (parameter N): req vector and enable in, one-hot grant out, rr_ptr update on accept.
- Channel FSM is instantiated twice through a generate loop inside raygroup_scheduler.

## Test plan
- Single request: req 2 submits ID 2'b11 with both channels idle -> raygroup01 = 3 and raygroupvalid01 pulses once. busy01 is held high for 5 cycles -> done_valid with done_req = 2, done_chan = 0, exactly 2 cycles after busy01 falls.
- Fairness: all 4 requesters valid continuously, each busy high for 3 cycles -> grant order 0,1,2,3,0 with channels alternating 01/10 and no starvation.
- Both channels busy: req 1 valid -> req_ready stays 0 until a channel returns to IDLE, then the grant goes to that channel.
- Simultaneous completion: busy01 and busy10 fall in the same cycle -> done_chan = 0 reported first and done_chan = 1 reported in the next cycle.
- Reset mid-operation: reset asserted during RUN -> all outputs take their reset values immediately, no done_valid is issued, and the next grant goes to requester 0.
- With RGSCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 16: busy10 is never raised -> done_chan = 1 reported within 18 cycles of ISSUE and timeout_err = 1 until reset.

Source files
------------

// File: rtl/raygroup_sched_pkg.sv
// Shared types for the ray-group channel scheduler: channel FSM states,
// channel encodings and the ray-group ID type.
package raygroup_sched_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} chan_state_e;
  localparam logic CHAN01 = 1'b0;
  localparam logic CHAN10 = 1'b1;
  typedef logic [1:0] raygroup_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// rr_ptr; rr_ptr advances past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] rr_ptr;
  logic [W-1:0] k;
  logic         found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        k = W'((int'(rr_ptr) + i) % N);
        if (!found && req[k]) begin
          found     = 1'b1;
          grant[k]  = 1'b1;
          grant_idx = k;
        end
      end
    end
  end

  // A grant only ever targets a valid requester, so a grant is a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rr_ptr <= '0;
    else if (found) rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/raygroup_scheduler.sv
// Shares engine channels 01 and 10 between NUM_REQ requesters.
// Optional watchdog: define RGSCHED_TIMEOUT_EN.
import raygroup_sched_pkg::*;

module raygroup_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_group,
  output logic [NUM_REQ-1:0]   req_ready,
  output raygroup_t            raygroup01,
  output logic                 raygroupvalid01,
  input  logic                 busy01,
  output raygroup_t            raygroup10,
  output logic                 raygroupvalid10,
  input  logic                 busy10,
  output logic                 done_valid,
  output logic [REQ_W-1:0]     done_req,
  output logic                 done_chan,
  output logic                 timeout_err
);
  chan_state_e        st    [2];
  raygroup_t          id_v  [2];
  logic [REQ_W-1:0]   own_v [2];
  logic [1:0]         busy, rpt;
  logic               run_q, any_idle, tgt;
  logic [NUM_REQ-1:0] grant;
  logic [REQ_W-1:0]   grant_idx;
  raygroup_t          gid;

  // Holds off grants while reset is asserted so req_ready reads 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign busy     = {busy10, busy01};
  assign any_idle = run_q && (st[0] == IDLE || st[1] == IDLE);
  assign tgt      = (st[0] == IDLE) ? CHAN01 : CHAN10;
  assign rpt[0]   = (st[0] == DONE);
  assign rpt[1]   = (st[1] == DONE) && (st[0] != DONE);
  assign gid      = req_group[{grant_idx, 1'b0} +: 2];

  rr_arbiter #(.N(NUM_REQ), .W(REQ_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (any_idle),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    localparam logic CH = (c == 1) ? CHAN10 : CHAN01;
    chan_state_e      st_q, st_nxt;
    raygroup_t        id_q;
    logic [REQ_W-1:0] own_q;
    logic             take;

    assign take = (st_q == IDLE) && (|grant) && (tgt == CH);

`ifdef RGSCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             tmo;
    // Fires on the TIMEOUT_CYCLES-th counted cycle of WAIT_BUSY/RUN.
    assign tmo = (st_q == WAIT_BUSY || st_q == RUN) &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                               cnt_q <= '0;
      else if (st_q == ISSUE)                   cnt_q <= '0;
      else if (st_q == WAIT_BUSY || st_q == RUN) cnt_q <= cnt_q + 1'b1;
    end
`endif

    always_comb begin
      st_nxt = st_q;
      unique case (st_q)
        IDLE:      if (take)     st_nxt = ISSUE;
        ISSUE:                   st_nxt = WAIT_BUSY;
        WAIT_BUSY: if (busy[c])  st_nxt = RUN;
        RUN:       if (!busy[c]) st_nxt = DONE;
        DONE:      if (rpt[c])   st_nxt = IDLE;
        default:                 st_nxt = IDLE;
      endcase
`ifdef RGSCHED_TIMEOUT_EN
      if (tmo) st_nxt = DONE;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q  <= IDLE;
        id_q  <= '0;
        own_q <= '0;
      end else begin
        st_q <= st_nxt;
        if (take) begin
          id_q  <= gid;
          own_q <= grant_idx;
        end else if (st_q == DONE && rpt[c]) begin
          id_q  <= '0;
          own_q <= '0;
        end
      end
    end

    assign st[c]    = st_q;
    assign id_v[c]  = id_q;
    assign own_v[c] = own_q;
  end

  assign raygroup01      = id_v[0];
  assign raygroup10      = id_v[1];
  assign raygroupvalid01 = (st[0] == ISSUE);
  assign raygroupvalid10 = (st[1] == ISSUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_valid <= 1'b0;
      done_req   <= '0;
      done_chan  <= CHAN01;
    end else begin
      done_valid <= |rpt;
      if (|rpt) begin
        done_chan <= rpt[0] ? CHAN01 : CHAN10;
        done_req  <= rpt[0] ? own_v[0] : own_v[1];
      end
    end
  end

`ifdef RGSCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             timeout_err <= 1'b0;
    else if (g_chan[0].tmo || g_chan[1].tmo) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_raygroup_scheduler.sv
// Directed bench for raygroup_scheduler; watchdog section follows RGSCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_raygroup_scheduler;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid, req_ready;
  logic [2*NR-1:0] req_group;
  logic [1:0]      raygroup01, raygroup10, done_req;
  logic            raygroupvalid01, raygroupvalid10, busy01, busy10;
  logic            done_valid, done_chan, timeout_err;
  logic            b01_man, b10_man, b01_auto, b10_auto, auto_en;
  int              nchk = 0, nerr = 0;
  int              c01 = 0, c10 = 0;

  always #5 clk = ~clk;

  assign busy01 = auto_en ? b01_auto : b01_man;
  assign busy10 = auto_en ? b10_auto : b10_man;

  raygroup_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_group(req_group), .req_ready(req_ready),
    .raygroup01(raygroup01), .raygroupvalid01(raygroupvalid01), .busy01(busy01),
    .raygroup10(raygroup10), .raygroupvalid10(raygroupvalid10), .busy10(busy10),
    .done_valid(done_valid), .done_req(done_req), .done_chan(done_chan),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Engine model: busy high for 3 cycles starting the cycle after each issue strobe.
  initial begin
    b01_auto = 1'b0; b10_auto = 1'b0;
    forever begin
      step();
      b01_auto = (c01 > 0); if (c01 > 0) c01--;
      b10_auto = (c10 > 0); if (c10 > 0) c10--;
      if (raygroupvalid01) c01 = 3;
      if (raygroupvalid10) c10 = 3;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  int exp_i [5] = '{0, 1, 2, 3, 0};
  int exp_c [5] = '{0, 1, 0, 1, 0};
  int gi [5], gc [5], gg [5];
  int ng, nc, pend, ndone, t, found;

  initial begin
    req_valid = '0; req_group = '0; b01_man = 0; b10_man = 0; auto_en = 0;
    #2 reset = 1'b0;
    repeat (3) step();
    req_valid = 4'hF; #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rg01", raygroup01, 0);
    chk("rst_rv01", raygroupvalid01, 0);
    chk("rst_rg10", raygroup10, 0);
    chk("rst_rv10", raygroupvalid10, 0);
    chk("rst_dv", done_valid, 0);
    chk("rst_dreq", done_req, 0);
    chk("rst_dchan", done_chan, 0);
    chk("rst_tmo", timeout_err, 0);
    req_valid = '0;
    reset = 1'b1;
    step();

    // Single request from requester 2, ID 3, busy01 high for 5 cycles
    req_group = 8'b00_11_00_00; req_valid = 4'b0100; #1;
    chk("s_ready", req_ready, 4'b0100);
    step(); req_valid = '0; #1;
    chk("s_rv01", raygroupvalid01, 1);
    chk("s_rg01", raygroup01, 3);
    chk("s_rv10", raygroupvalid10, 0);
    step(); b01_man = 1;
    chk("s_rv01_pulse", raygroupvalid01, 0);
    chk("s_rg01_hold", raygroup01, 3);
    repeat (4) step();
    step(); b01_man = 0;
    step(); chk("s_dv_early", done_valid, 0);
    step();
    chk("s_dv", done_valid, 1);
    chk("s_dreq", done_req, 2);
    chk("s_dchan", done_chan, 0);
    step();
    chk("s_dv_pulse", done_valid, 0);
    chk("s_rg01_clr", raygroup01, 0);

    // Fairness: all valid, engine model responds
    do_reset();
    req_group = {2'd3, 2'd2, 2'd1, 2'd0}; auto_en = 1; req_valid = 4'hF; #1;
    ng = 0; nc = 0; pend = 0;
    for (int k = 0; k < 80 && nc < 5; k++) begin
      if (pend != 0) begin
        gc[nc] = raygroupvalid10 ? 1 : 0;
        gg[nc] = raygroupvalid10 ? int'(raygroup10) : int'(raygroup01);
        nc++; pend = 0;
      end
      if (req_ready != 0 && ng < 5) begin
        chk("f_onehot", {31'd0, $onehot(req_ready)}, 1);
        gi[ng] = oh2i(req_ready); ng++; pend = 1;
      end
      step();
      if (ng == 5) req_valid = '0;
      #1;
    end
    chk("f_count", nc, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("f_idx%0d", k), gi[k], exp_i[k]);
      chk($sformatf("f_chan%0d", k), gc[k], exp_c[k]);
      chk($sformatf("f_id%0d", k), gg[k], exp_i[k]);
    end
    repeat (15) step();
    auto_en = 0;

    // Both channels busy, then simultaneous completion
    do_reset();
    req_group = 8'b00_10_01_01;
    req_valid = 4'b0001; #1; chk("b_r0", req_ready, 4'b0001);
    step(); req_valid = 4'b0100; #1; chk("b_r2", req_ready, 4'b0100);
    step(); b01_man = 1; req_valid = 4'b0010; #1;
    chk("b_full0", req_ready, 0);
    chk("b_rg10", raygroup10, 2);
    step(); b10_man = 1; #1; chk("b_full1", req_ready, 0);
    step(); b10_man = 0; #1; chk("b_full2", req_ready, 0);
    step(); #1; chk("b_done_state", req_ready, 0);
    step(); #1;
    chk("b_regrant", req_ready, 4'b0010);
    chk("b_dv", done_valid, 1);
    chk("b_dchan", done_chan, 1);
    chk("b_dreq", done_req, 2);
    step(); req_valid = '0;
    chk("b_rv10", raygroupvalid10, 1);
    chk("b_rv01", raygroupvalid01, 0);
    chk("b_rg10_new", raygroup10, 1);
    step(); b10_man = 1;
    step(); b01_man = 0; b10_man = 0;
    step(); chk("c_dv0", done_valid, 0);
    step();
    chk("c_dv1", done_valid, 1);
    chk("c_chan1", done_chan, 0);
    chk("c_req1", done_req, 0);
    step();
    chk("c_dv2", done_valid, 1);
    chk("c_chan2", done_chan, 1);
    chk("c_req2", done_req, 1);
    step(); chk("c_dv3", done_valid, 0);

    // Reset during RUN
    do_reset();
    req_group = 8'b11_00_00_00; req_valid = 4'b1000; #1;
    chk("r_ready", req_ready, 4'b1000);
    step(); req_valid = '0;
    step(); b01_man = 1;
    step(); step();
    chk("r_rg01_run", raygroup01, 3);
    reset = 1'b0; req_valid = 4'hF; #1;
    chk("r_ready0", req_ready, 0);
    chk("r_rg01", raygroup01, 0);
    chk("r_dv", done_valid, 0);
    step(); step(); b01_man = 0; req_valid = '0;
    reset = 1'b1;
    ndone = 0;
    repeat (8) begin step(); if (done_valid) ndone++; end
    chk("r_nodone", ndone, 0);
    req_valid = 4'hF; #1;
    chk("r_first", req_ready, 4'b0001);
    req_valid = '0;

    // Channel 10 never sees busy
    do_reset();
    req_group = 8'b00_00_10_01;
    req_valid = 4'b0001; step();
    req_valid = 4'b0010; #1; chk("t_ready", req_ready, 4'b0010);
    step(); b01_man = 1; req_valid = '0;
    chk("t_rv10", raygroupvalid10, 1);
    t = 0; found = 0;
    while (t < 30 && found == 0) begin
      step(); t++;
      if (done_valid && done_chan) found = 1;
    end
`ifdef RGSCHED_TIMEOUT_EN
    chk("t_seen", found, 1);
    chk("t_lat", {31'd0, t <= 18}, 1);
    chk("t_err", timeout_err, 1);
    repeat (3) step();
    chk("t_err_sticky", timeout_err, 1);
`else
    chk("t_noreport", found, 0);
    chk("t_err0", timeout_err, 0);
`endif
    b01_man = 0;
    reset = 1'b0; #1;
    chk("t_err_rst", timeout_err, 0);
    step(); reset = 1'b1; step();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
